// File: rtl/riscv_muldiv_unit_pkg.sv
// riscv_muldiv_unit_pkg
//   Shared definitions for the M-extension multiply/divide unit:
//   default XLEN, RV M-ext funct3 codes, FSM state encodings and
//   small funct3 decode helpers.
package riscv_muldiv_unit_pkg;

  localparam int unsigned MULDIV_XLEN = 32;

  // RV M-extension funct3 codes
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  function automatic logic f3_is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  function automatic logic f3_is_rem(input logic [2:0] f3);
    return f3[2] & f3[1];
  endfunction

  // rs1 is treated as signed for MULH, MULHSU, DIV, REM
  function automatic logic f3_a_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // rs2 is treated as signed for MULH, DIV, REM
  function automatic logic f3_b_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// muldiv_div_step
//   One combinational restoring-divide iteration on magnitudes.
// Ports
//   rem_in        in   XLEN  partial remainder (always < divisor)
//   dividend_bit  in   1     next dividend bit shifted into the remainder
//   divisor       in   XLEN  divisor magnitude
//   rem_out       out  XLEN  updated partial remainder
//   q_bit         out  1     quotient bit produced by this iteration
module muldiv_div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic            dividend_bit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);

  logic [XLEN:0] w_shifted;
  logic [XLEN:0] w_diff;

  assign w_shifted = {rem_in, dividend_bit};
  assign w_diff    = w_shifted - {1'b0, divisor};
  // rem_in < divisor bounds the shifted value below 2*divisor, so the top bit
  // of the difference is a reliable borrow flag.
  assign q_bit     = ~w_diff[XLEN];
  assign rem_out   = q_bit ? w_diff[XLEN-1:0] : w_shifted[XLEN-1:0];

endmodule

// File: rtl/riscv_muldiv_unit.sv
// riscv_muldiv_unit
//   Multi-cycle RV32M/RV64M multiply/divide unit beside the ALU.
//   Shift-add multiplier and restoring divider working on operand
//   magnitudes, with sign correction applied in a final FIX cycle.
//   Optional macro MULDIV_FAST_MUL_EN: multiplies use one combinational
//   (XLEN+1)x(XLEN+1) signed multiplier instead of iterating.
// Ports
//   clk, rst                  clock, async active-low reset
//   start_valid/start_ready   op request handshake
//   funct3, op_a, op_b        M-ext op and rs1/rs2 values
//   kill                      synchronous flush of the in-flight op
//   result_valid/result_ready result handshake
//   result                    result value
//   busy                      unit not idle
module riscv_muldiv_unit
  import riscv_muldiv_unit_pkg::*;
#(
  parameter int unsigned XLEN = MULDIV_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            kill,
  output logic            result_valid,
  input  logic            result_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned     CNT_W      = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_f3;
  logic              r_neg_main;
  logic              r_neg_rem;
  logic              r_spec;
  logic [XLEN-1:0]   r_opnd;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_result;

  logic              w_accept;
  logic              w_is_div;
  logic              w_sa;
  logic              w_sb;
  logic              w_div_zero;
  logic              w_div_ovf;
  logic [XLEN-1:0]   w_amag;
  logic [XLEN-1:0]   w_bmag;
  logic [XLEN-1:0]   w_spec_res;
  logic [XLEN-1:0]   w_rem_step;
  logic              w_qbit;
  logic [2*XLEN-1:0] w_acc_next;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo_fix;
  logic [XLEN-1:0]   w_rem_fix;
  logic [XLEN-1:0]   w_fix_res;

  assign start_ready  = (r_state == ST_IDLE) && !kill;
  assign result_valid = (r_state == ST_DONE);
  assign result       = r_result;
  assign busy         = (r_state != ST_IDLE);

  // Operand decode at accept
  assign w_accept   = start_valid && start_ready;
  assign w_is_div   = f3_is_div(funct3);
  assign w_sa       = f3_a_signed(funct3) && op_a[XLEN-1];
  assign w_sb       = f3_b_signed(funct3) && op_b[XLEN-1];
  assign w_amag     = w_sa ? -op_a : op_a;
  assign w_bmag     = w_sb ? -op_b : op_b;
  assign w_div_zero = w_is_div && (op_b == '0);
  assign w_div_ovf  = w_is_div && f3_b_signed(funct3) && (op_a == SIGNED_MIN) && (op_b == '1);
  assign w_spec_res = w_div_zero ? (f3_is_rem(funct3) ? op_a : '1)
                                 : (f3_is_rem(funct3) ? '0 : op_a);

  // r_acc: multiply = {partial product high, multiplier/product low};
  //        divide   = {remainder, dividend/quotient}
  muldiv_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_in       (r_acc[2*XLEN-1:XLEN]),
    .dividend_bit (r_acc[XLEN-1]),
    .divisor      (r_opnd),
    .rem_out      (w_rem_step),
    .q_bit        (w_qbit)
  );

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_prod;
  assign w_fast_prod = (2*XLEN)'($signed({1'b0, r_opnd}) * $signed({1'b0, r_acc[XLEN-1:0]}));
  assign w_acc_next  = f3_is_div(r_f3) ? {w_rem_step, r_acc[XLEN-2:0], w_qbit} : w_fast_prod;
`else
  logic [XLEN:0] w_mul_sum;
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_acc_next = f3_is_div(r_f3) ? {w_rem_step, r_acc[XLEN-2:0], w_qbit}
                                      : {w_mul_sum, r_acc[XLEN-1:1]};
`endif

  // Sign correction and result selection
  assign w_prod_fix = r_neg_main ? -r_acc : r_acc;
  assign w_quo_fix  = r_neg_main ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem_fix  = r_neg_rem  ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_fix_res = w_rem_fix;
    case (r_f3)
      F3_MUL:                       w_fix_res = w_prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              w_fix_res = w_quo_fix;
      F3_REM, F3_REMU:              w_fix_res = w_rem_fix;
      default:                      w_fix_res = w_rem_fix;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_f3       <= '0;
      r_neg_main <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_spec     <= 1'b0;
      r_opnd     <= '0;
      r_acc      <= '0;
      r_result   <= '0;
    end else if (kill) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_f3       <= funct3;
            r_neg_main <= w_sa ^ w_sb;
            r_neg_rem  <= w_sa;
            r_acc      <= {{XLEN{1'b0}}, (w_is_div ? w_amag : w_bmag)};
            r_opnd     <= w_is_div ? w_bmag : w_amag;
            r_spec     <= w_div_zero || w_div_ovf;
            // Special divides skip CALC; FIX only forwards the preset result,
            // which keeps their valid one edge after accept.
            if (w_div_zero || w_div_ovf) begin
              r_result <= w_spec_res;
              r_state  <= ST_FIX;
            end else begin
              r_state <= ST_CALC;
`ifdef MULDIV_FAST_MUL_EN
              // One CALC cycle registers the full product from latched operands
              r_cnt   <= w_is_div ? CNT_W'(XLEN-1) : '0;
`else
              r_cnt   <= CNT_W'(XLEN-1);
`endif
            end
          end
        end
        ST_CALC: begin
          r_acc <= w_acc_next;
          if (r_cnt == '0) r_state <= ST_FIX;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        ST_FIX: begin
          if (!r_spec) r_result <= w_fix_res;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (result_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// tb_riscv_muldiv_unit
//   Self-checking bench for riscv_muldiv_unit (XLEN=32): directed vectors,
//   randomized ops against an arithmetic reference model, backpressure,
//   kill and asynchronous reset behaviour.
module tb_riscv_muldiv_unit;

  localparam int unsigned XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 33;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            start_valid;
  logic            start_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            kill;
  logic            result_valid;
  logic            result_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  riscv_muldiv_unit #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .funct3       (funct3),
    .op_a         (op_a),
    .op_b         (op_b),
    .kill         (kill),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V M-extension semantics from plain 64-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    case (f3)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return MUL_LAT;
    if (b == 0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issue one op with result_ready=1; check latency, value, one-cycle pulse.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input string tag);
    int n;
    logic [31:0] exp_r;
    exp_r = model(f3, a, b);
    @(negedge clk);
    start_valid = 1'b1; funct3 = f3; op_a = a; op_b = b;
    @(posedge clk); #1;
    start_valid = 1'b0;
    funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
    n = 0;
    while (!result_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, " valid"}, 64'(result_valid), 64'(1));
    chk({tag, " latency"}, 64'(n), 64'(exp_lat(f3, a, b)));
    chk({tag, " result"}, 64'(result), 64'(exp_r));
    @(posedge clk); #1;
    chk({tag, " pulse"}, 64'(result_valid), 64'(0));
  endtask

  initial begin
    int n;
    int seen;
    logic [31:0] ra, rb, held;
    logic [2:0]  rf;

    rst = 1'b0; start_valid = 1'b0; kill = 1'b0; result_ready = 1'b1;
    funct3 = '0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst valid", 64'(result_valid), 64'(0));
    chk("rst result", 64'(result), 64'(0));
    chk("rst busy", 64'(busy), 64'(0));
    @(negedge clk); rst = 1'b1; #1;
    chk("rst ready", 64'(start_ready), 64'(1));

    // Directed vectors
    do_op(3'd0, 32'd7,          32'hFFFF_FFFD, "MUL");
    do_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, "MULHU");
    do_op(3'd1, 32'h8000_0000,  32'h8000_0000, "MULH");
    do_op(3'd2, 32'hFFFF_FFFF,  32'd2,         "MULHSU");
    do_op(3'd4, 32'hFFFF_FFF9,  32'd2,         "DIV");
    do_op(3'd6, 32'hFFFF_FFF9,  32'd2,         "REM");
    do_op(3'd5, 32'd100,        32'd7,         "DIVU");
    do_op(3'd7, 32'd100,        32'd7,         "REMU");
    do_op(3'd5, 32'd5,          32'd0,         "DIVU by0");
    do_op(3'd6, 32'd5,          32'd0,         "REM by0");
    do_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, "DIV ovf");
    do_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, "REM ovf");

    // Randomized ops with corner injection
    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'($urandom_range(0, 255));
        default: ;
      endcase
      do_op(rf, ra, rb, "rand");
    end

    // Backpressure: result held in DONE, no accept while waiting
    result_ready = 1'b0;
    @(negedge clk);
    start_valid = 1'b1; funct3 = 3'd5; op_a = 32'd1000; op_b = 32'd7;
    @(posedge clk); #1;
    funct3 = 3'd0; op_a = 32'd3; op_b = 32'd3;
    n = 0;
    while (!result_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("bp valid", 64'(result_valid), 64'(1));
    held = result;
    chk("bp result", 64'(held), 64'(142));
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("bp hold valid", 64'(result_valid), 64'(1));
      chk("bp hold result", 64'(result), 64'(142));
      chk("bp ready low", 64'(start_ready), 64'(0));
    end
    @(negedge clk);
    start_valid = 1'b0; result_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp take valid", 64'(result_valid), 64'(0));
    chk("bp take busy", 64'(busy), 64'(0));

    // Kill mid-operation at E0+5
    @(negedge clk);
    start_valid = 1'b1; funct3 = 3'd0; op_a = 32'd12345; op_b = 32'd678;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    kill = 1'b1; #1;
    chk("kill ready", 64'(start_ready), 64'(0));
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill busy", 64'(busy), 64'(0));
    chk("kill valid", 64'(result_valid), 64'(0));
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (result_valid) seen = 1;
    end
    chk("kill no result", 64'(seen), 64'(0));

    // Kill beats start in the same cycle
    @(negedge clk);
    start_valid = 1'b1; kill = 1'b1; funct3 = 3'd5; op_a = 32'd9; op_b = 32'd3;
    @(posedge clk); #1;
    start_valid = 1'b0; kill = 1'b0;
    chk("kill beats start", 64'(busy), 64'(0));

    // Asynchronous reset mid-operation clears outputs at once
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "pre-rst");
    @(negedge clk);
    start_valid = 1'b1; funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd3;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (9) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst valid", 64'(result_valid), 64'(0));
    chk("arst busy", 64'(busy), 64'(0));
    chk("arst result", 64'(result), 64'(0));
    @(negedge clk); rst = 1'b1; #1;
    chk("arst ready", 64'(start_ready), 64'(1));
    do_op(3'd6, 32'hFFFF_FF00, 32'd7, "post-rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
